// File: rtl/jts16_sndcomm.sv
// jts16_sndcomm: main/sound CPU command channel (16A latch or 16B FIFO) plus a reply latch.
module jts16_sndcomm #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          main_wr,
  input  logic [DW-1:0] main_din,
  input  logic          main_rd,
  output logic [DW-1:0] main_dout,
  output logic          main_obf,
  output logic          main_full,
  input  logic          snd_rd,
  input  logic          snd_ack,
  output logic [DW-1:0] snd_dout,
  output logic          snd_irqn,
  input  logic          snd_wr,
  input  logic [DW-1:0] snd_din,
  output logic [AW:0]   level,
  output logic          ovf
);
  localparam logic [AW:0] full_lvl = (AW+1)'(DEPTH);
  localparam bit m1 = (MODE == 1);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic [DW-1:0] last;
  logic          push, pop, drop;
  assign pop  = m1 && snd_rd && cnt != '0;
  assign push = m1 && main_wr && (cnt != full_lvl || pop);
  // a 16A write over an unacknowledged command is lost unless the ack lands in the same cycle
  assign drop = m1 ? main_wr && cnt == full_lvl && !pop : main_wr && cnt[0] && !snd_ack;
  always_ff @(posedge clk)
    if (push) mem[wp] <= main_din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      last      <= '0;
      ovf       <= 1'b0;
      main_dout <= '0;
      main_obf  <= 1'b0;
    end else begin
      if (m1) begin
        wp  <= wp + AW'(push);
        rp  <= rp + AW'(pop);
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        if (pop) last <= mem[rp];
      end else begin
        cnt <= main_wr ? (AW+1)'(1) : snd_ack ? '0 : cnt;
        if (main_wr) last <= main_din;
      end
      ovf       <= ovf | drop;
      main_dout <= snd_wr ? snd_din : main_dout;
      main_obf  <= snd_wr | (main_obf & ~main_rd);
    end
  // when empty, show the last popped byte rather than stale storage
  assign snd_dout  = (m1 && cnt != '0) ? mem[rp] : last;
  assign snd_irqn  = cnt == '0;
  assign main_full = m1 && cnt == full_lvl;
  assign level     = cnt;
endmodule

// File: tb/tb_jts16_sndcomm.sv
// tb_jts16_sndcomm: drives a FIFO-mode and a latch-mode instance with shared strobes and
// checks both against a queue-based model every cycle.
module tb_jts16_sndcomm;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic main_wr = 0, main_rd = 0, snd_rd = 0, snd_ack = 0, snd_wr = 0;
  logic [7:0] main_din = 0, snd_din = 0;
  logic [7:0] f_mdout, f_sdout, l_mdout, l_sdout;
  logic f_obf, f_full, f_irqn, f_ovf, l_obf, l_full, l_irqn, l_ovf;
  logic [2:0] f_level, l_level;
  int errors = 0, checks = 0;
  bit run = 0;
  byte unsigned q[$];
  logic [7:0] last1, lat0, rdout;
  bit pend0, obf, ovf1, ovf0;

  always #5 clk = ~clk;

  jts16_sndcomm #(.DW(8), .DEPTH(DEPTH), .MODE(1)) u_fifo (
    .clk(clk), .rst_n(rst_n), .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd),
    .main_dout(f_mdout), .main_obf(f_obf), .main_full(f_full), .snd_rd(snd_rd),
    .snd_ack(snd_ack), .snd_dout(f_sdout), .snd_irqn(f_irqn), .snd_wr(snd_wr),
    .snd_din(snd_din), .level(f_level), .ovf(f_ovf));

  jts16_sndcomm #(.DW(8), .DEPTH(DEPTH), .MODE(0)) u_latch (
    .clk(clk), .rst_n(rst_n), .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd),
    .main_dout(l_mdout), .main_obf(l_obf), .main_full(l_full), .snd_rd(snd_rd),
    .snd_ack(snd_ack), .snd_dout(l_sdout), .snd_irqn(l_irqn), .snd_wr(snd_wr),
    .snd_din(snd_din), .level(l_level), .ovf(l_ovf));

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    last1 = 0; lat0 = 0; rdout = 0;
    pend0 = 0; obf = 0; ovf1 = 0; ovf0 = 0;
  endfunction

  always @(negedge clk) if (run) begin
    chk("f_level", f_level, q.size());
    chk("f_sdout", f_sdout, q.size() > 0 ? q[0] : last1);
    chk("f_irqn", f_irqn, q.size() == 0);
    chk("f_full", f_full, q.size() == DEPTH);
    chk("f_ovf", f_ovf, ovf1);
    chk("f_mdout", f_mdout, rdout);
    chk("f_obf", f_obf, obf);
    chk("l_level", l_level, pend0);
    chk("l_sdout", l_sdout, lat0);
    chk("l_irqn", l_irqn, !pend0);
    chk("l_full", l_full, 0);
    chk("l_ovf", l_ovf, ovf0);
    chk("l_mdout", l_mdout, rdout);
    chk("l_obf", l_obf, obf);
  end

  task automatic step(input bit wr, input logic [7:0] din, input bit rd, input bit srd,
                      input bit ack, input bit swr, input logic [7:0] sdin);
    bit pop_ok, push_ok;
    main_wr = wr; main_din = din; main_rd = rd; snd_rd = srd;
    snd_ack = ack; snd_wr = swr; snd_din = sdin;
    @(posedge clk);
    pop_ok  = srd && q.size() > 0;
    push_ok = wr && (q.size() < DEPTH || pop_ok);
    if (wr && !push_ok) ovf1 = 1;
    if (pop_ok) last1 = q.pop_front();
    if (push_ok) q.push_back(din);
    if (wr) begin
      if (pend0 && !ack) ovf0 = 1;
      lat0 = din;
      pend0 = 1;
    end else if (ack) pend0 = 0;
    if (swr) begin rdout = sdin; obf = 1; end
    else if (rd) obf = 0;
    #1;
  endtask

  task automatic do_reset();
    main_wr = 0; main_rd = 0; snd_rd = 0; snd_ack = 0; snd_wr = 0;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_level", f_level, 0);
    chk("rst_irqn", f_irqn, 1);
    chk("rst_obf", f_obf, 0);
    chk("rst_full", f_full, 0);
    chk("rst_ovf", f_ovf, 0);
    chk("rst_mdout", f_mdout, 0);
    chk("rst_sdout", f_sdout, 0);
    chk("rst_l_sdout", l_sdout, 0);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic push(input logic [7:0] d); step(1, d, 0, 0, 0, 0, 0); endtask
  task automatic pop(); step(0, 0, 0, 1, 0, 0, 0); endtask

  initial begin
    model_reset();
    run = 1;
    do_reset();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("d40_level", f_level, 4);
    chk("d40_full", f_full, 1);
    chk("d40_head", f_sdout, 8'h11);
    chk("d40_irqn", f_irqn, 0);
    push(8'h55);
    chk("d40_ovf", f_ovf, 1);
    chk("d40_level_ovf", f_level, 4);
    pop(); chk("d40_pop1", f_sdout, 8'h22);
    pop(); chk("d40_pop2", f_sdout, 8'h33);
    pop(); chk("d40_pop3", f_sdout, 8'h44);
    pop(); chk("d40_empty_irqn", f_irqn, 1);
    chk("d40_empty_level", f_level, 0);
    chk("d40_hold", f_sdout, 8'h44);
    do_reset();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    step(1, 8'h66, 0, 1, 0, 0, 0);
    chk("d41_level", f_level, 4);
    chk("d41_ovf", f_ovf, 0);
    pop(); pop(); pop();
    chk("d41_66", f_sdout, 8'h66);
    pop();
    step(1, 8'h77, 0, 1, 0, 0, 0);
    chk("d42_level", f_level, 1);
    chk("d42_dout", f_sdout, 8'h77);
    pop();
    for (int i = 0; i < 10; i++) begin
      push(8'(8'h80 + i));
      if (i % 2 == 1) begin pop(); pop(); end
    end
    do_reset();
    push(8'hA5);
    chk("d44_irqn", l_irqn, 0);
    chk("d44_a5", l_sdout, 8'hA5);
    chk("d44_ovf0", l_ovf, 0);
    push(8'h5A);
    chk("d44_ovf", l_ovf, 1);
    chk("d44_5a", l_sdout, 8'h5A);
    chk("d44_notfull", l_full, 0);
    step(1, 8'h3C, 0, 0, 1, 0, 0);
    chk("d44_wr_ack", l_irqn, 0);
    chk("d44_3c", l_sdout, 8'h3C);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("d44_ack", l_irqn, 1);
    step(0, 0, 0, 0, 0, 1, 8'hC3);
    chk("d45_obf", f_obf, 1);
    chk("d45_c3", f_mdout, 8'hC3);
    step(0, 0, 1, 0, 0, 1, 8'h3C);
    chk("d45_obf_both", f_obf, 1);
    chk("d45_3c", f_mdout, 8'h3C);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("d45_rd", f_obf, 0);
    chk("d45_hold", f_mdout, 8'h3C);
    step(0, 0, 0, 0, 0, 1, 8'h99);
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 99) < 50, 8'($urandom), $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 30, 8'($urandom));
    end
    @(negedge clk);
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jts16_sndcomm.md
JTS16_SNDCOMM -- requirements
Module: jts16_sndcomm

Parameters
REQ-001 DW, 8, data width of both command and reply paths.
REQ-002 DEPTH, 4, command FIFO depth; power of two, 2..64; AW=log2(DEPTH).
REQ-003 MODE, 1, 0 = System 16A single latch with IRQ/ack; 1 = System 16B mapper FIFO with OBF.

Interface
REQ-004 clk  in  1  system clock; every register updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 main_wr  in  1  main CPU command write strobe, one clk per write.
REQ-007 main_din  in  DW  command byte.
REQ-008 main_rd  in  1  main CPU reply read strobe, one clk per read.
REQ-009 main_dout  out  DW  reply register contents.
REQ-010 main_obf  out  1  reply pending for the main CPU.
REQ-011 main_full  out  1  command path cannot accept data.
REQ-012 snd_rd  in  1  sound CPU pop strobe (MODE 1 only).
REQ-013 snd_ack  in  1  sound CPU IRQ acknowledge strobe (MODE 0 only).
REQ-014 snd_dout  out  DW  command head (MODE 1) or latch contents (MODE 0).
REQ-015 snd_irqn  out  1  active-low: command available.
REQ-016 snd_wr  in  1  sound CPU reply write strobe.
REQ-017 snd_din  in  DW  reply byte.
REQ-018 level  out  AW+1  FIFO occupancy, 0..DEPTH; in MODE 0, 1 while a command is pending, else 0.
REQ-019 ovf  out  1  sticky flag: a command was lost.

Function
REQ-020 MODE 1: main_wr with level<DEPTH pushes main_din; level, snd_dout and snd_irqn reflect it at cycle n+1.
REQ-021 MODE 1: snd_rd with level>0 pops the head; snd_dout shows the next entry at n+1.
REQ-022 MODE 1: snd_dout always equals the oldest unread entry; when empty it holds the last popped value.
REQ-023 MODE 1: snd_irqn = (level==0); main_full = (level==DEPTH).
REQ-024 MODE 1: a push while full is dropped and sets ovf; FIFO contents are unchanged.
REQ-025 MODE 1: simultaneous push+pop when full: both execute, level unchanged, ovf not set.
REQ-026 MODE 1: simultaneous push+pop when empty: the pop is ignored, the push executes, level=1.
REQ-027 MODE 1: read/write pointers wrap modulo DEPTH without gaps or reordering.
REQ-028 MODE 0: main_wr loads the latch into snd_dout and drives snd_irqn low at n+1.
REQ-029 MODE 0: snd_ack drives snd_irqn high at n+1; snd_rd has no effect.
REQ-030 MODE 0: simultaneous main_wr+snd_ack: the write wins, snd_irqn stays low, and the latch takes new data.
REQ-031 MODE 0: main_wr while snd_irqn is low overwrites the latch and sets ovf; main_full is held at 0.
REQ-032 Reply path, both modes: snd_wr loads main_dout and sets main_obf at n+1.
REQ-033 Reply path: main_rd clears main_obf at n+1; main_dout holds its value.
REQ-034 Reply path: simultaneous snd_wr+main_rd: new data is loaded and main_obf stays 1.
REQ-035 All strobes are level-sampled each clk; a strobe held for k cycles is k operations.
REQ-036 No combinational path from any input to any output except snd_dout, which reads the FIFO memory at the read pointer.

Reset
REQ-037 rst_n low asynchronously clears: pointers, level=0, snd_irqn=1, main_obf=0, main_full=0, ovf=0, main_dout=0, snd_dout=0.
REQ-038 Reset mid-operation discards all pending commands and replies; the first operation after deassertion behaves as from empty.
REQ-039 FIFO storage contents need no reset; outputs shall not expose stale storage after reset.

Verification
REQ-040 MODE 1, DEPTH 4: push 0x11,0x22,0x33,0x44 -> level=4, main_full=1, snd_dout=0x11, snd_irqn=0; push 0x55 -> ovf=1, level=4; four pops -> 0x22,0x33,0x44, then empty with snd_irqn=1.
REQ-041 MODE 1, full FIFO: push 0x66 and pop in the same cycle -> level stays 4, ovf=0, 0x66 is read after three more pops.
REQ-042 MODE 1, empty FIFO: push 0x77 and pop in the same cycle -> level=1, snd_dout=0x77.
REQ-043 MODE 1: push 10 times interleaved with pops to wrap the pointers twice -> output order equals input order.
REQ-044 MODE 0: write 0xA5 -> snd_irqn=0 at n+1; write 0x5A -> ovf=1, snd_dout=0x5A; write 0x3C with snd_ack in the same cycle -> snd_irqn=0; snd_ack alone -> snd_irqn=1.
REQ-045 Reply path: snd_wr 0xC3 -> main_obf=1, main_dout=0xC3; snd_wr 0x3C with main_rd in the same cycle -> main_obf=1, main_dout=0x3C; main_rd -> main_obf=0; rst_n pulsed mid-sequence -> all outputs at their REQ-037 values.
